// File: rtl/bcd_event_counter.sv
// bcd_event_counter: counts synchronized active-low key presses as a multi-digit
// BCD value and drives per-digit enables with optional leading-zero blanking.
module bcd_event_counter #(
   parameter int DIGITS   = 6,
   parameter int SATURATE = 0,
   parameter int BLANK    = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  inc_key,
   input  logic                  dec_key,
   input  logic                  clear,
   output logic [4*DIGITS-1:0]   digits,
   output logic [DIGITS-1:0]     digit_en,
   output logic                  overflow,
   output logic                  underflow
);
   localparam logic [DIGITS-1:0] EN_RST = (BLANK != 0) ? DIGITS'(1) : {DIGITS{1'b1}};
   logic [2:0]            inc_sync_q, inc_sync_d, dec_sync_q, dec_sync_d;
   logic [4*DIGITS-1:0]   digits_q, digits_d, inc_val, dec_val;
   logic [DIGITS-1:0]     digit_en_q, digit_en_d;
   logic                  overflow_q, overflow_d, underflow_q, underflow_d;
   logic                  inc_p, dec_p, carry, borrow, nz;
   logic [3:0]            dig;
   // sync chain bits: [0] first stage, [1] second stage, [2] previous value
   always_comb begin
      inc_sync_d = {inc_sync_q[1:0], inc_key};
      dec_sync_d = {dec_sync_q[1:0], dec_key};
      inc_p = inc_sync_q[2] & ~inc_sync_q[1];
      dec_p = dec_sync_q[2] & ~dec_sync_q[1];
      inc_val = '0;
      dec_val = '0;
      dig = 4'd0;
      carry = 1'b1;
      borrow = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         dig = digits_q[4*i +: 4];
         inc_val[4*i +: 4] = carry ? ((dig == 4'd9) ? 4'd0 : dig + 4'd1) : dig;
         dec_val[4*i +: 4] = borrow ? ((dig == 4'd0) ? 4'd9 : dig - 4'd1) : dig;
         carry = carry & (dig == 4'd9);
         borrow = borrow & (dig == 4'd0);
      end
      // carry/borrow surviving all digits marks the all-nines / all-zeros limit
      digits_d = digits_q;
      overflow_d = 1'b0;
      underflow_d = 1'b0;
      if (clear)
         digits_d = '0;
      else if (inc_p & ~dec_p) begin
         overflow_d = carry;
         digits_d = (carry && SATURATE != 0) ? digits_q : inc_val;
      end else if (dec_p & ~inc_p) begin
         underflow_d = borrow;
         digits_d = (borrow && SATURATE != 0) ? digits_q : dec_val;
      end
      nz = 1'b0;
      digit_en_d = {DIGITS{1'b1}};
      for (int i = DIGITS - 1; i > 0; i--) begin
         nz = nz | (digits_d[4*i +: 4] != 4'd0);
         digit_en_d[i] = nz | (BLANK == 0);
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inc_sync_q  <= 3'b111;
         dec_sync_q  <= 3'b111;
         digits_q    <= '0;
         digit_en_q  <= EN_RST;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         inc_sync_q  <= inc_sync_d;
         dec_sync_q  <= dec_sync_d;
         digits_q    <= digits_d;
         digit_en_q  <= digit_en_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end
   assign digits    = digits_q;
   assign digit_en  = digit_en_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;
endmodule

// File: tb/tb_bcd_event_counter.sv
// tb_bcd_event_counter: two configurations (6-digit wrap/blank, 2-digit saturate/no-blank)
// checked every cycle against an integer model of key-press counting.
module tb_bcd_event_counter;
   logic clk = 1'b0, reset_n = 1'b0, inc_key = 1'b1, dec_key = 1'b1, clear = 1'b0;
   logic [23:0] digits0;
   logic [5:0]  en0;
   logic        ovf0, unf0;
   logic [7:0]  digits1;
   logic [1:0]  en1;
   logic        ovf1, unf1;
   int n_checks = 0, n_fail = 0;
   int m0 = 0, m1 = 0;
   logic mo0 = 0, mu0 = 0, mo1 = 0, mu1 = 0;
   logic [2:0] ih = 3'b111, dh = 3'b111;
   logic ip, dp;

   always #5 clk = ~clk;

   bcd_event_counter dut0 (
      .clk(clk), .reset_n(reset_n), .inc_key(inc_key), .dec_key(dec_key), .clear(clear),
      .digits(digits0), .digit_en(en0), .overflow(ovf0), .underflow(unf0));

   bcd_event_counter #(.DIGITS(2), .SATURATE(1), .BLANK(0)) dut1 (
      .clk(clk), .reset_n(reset_n), .inc_key(inc_key), .dec_key(dec_key), .clear(clear),
      .digits(digits1), .digit_en(en1), .overflow(ovf1), .underflow(unf1));

   function automatic logic [31:0] bcd(int v, int n);
      logic [31:0] r = '0;
      for (int i = 0; i < n; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic logic [5:0] en6(int v);
      logic [5:0] r = 6'b1;
      int p = 10;
      for (int i = 1; i < 6; i++) begin
         r[i] = (v >= p);
         p = p * 10;
      end
      return r;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // a key sampled low right after a sampled-high takes effect two edges later
   assign ip = ih[2] & ~ih[1];
   assign dp = dh[2] & ~dh[1];

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m0 <= 0; m1 <= 0; mo0 <= 0; mu0 <= 0; mo1 <= 0; mu1 <= 0;
         ih <= 3'b111; dh <= 3'b111;
      end else begin
         ih <= {ih[1:0], inc_key};
         dh <= {dh[1:0], dec_key};
         mo0 <= !clear && ip && !dp && m0 == 999999;
         mu0 <= !clear && dp && !ip && m0 == 0;
         mo1 <= !clear && ip && !dp && m1 == 99;
         mu1 <= !clear && dp && !ip && m1 == 0;
         m0 <= clear ? 0 : (ip && !dp) ? (m0 + 1) % 1000000 :
               (dp && !ip) ? (m0 + 999999) % 1000000 : m0;
         m1 <= clear ? 0 : (ip && !dp) ? ((m1 == 99) ? 99 : m1 + 1) :
               (dp && !ip) ? ((m1 == 0) ? 0 : m1 - 1) : m1;
      end
   end

   always @(negedge clk) begin
      chk("digits0", digits0, bcd(m0, 6));
      chk("en0", en0, en6(m0));
      chk("ovf0", ovf0, mo0);
      chk("unf0", unf0, mu0);
      chk("digits1", digits1, bcd(m1, 2));
      chk("en1", en1, 2'b11);
      chk("ovf1", ovf1, mo1);
      chk("unf1", unf1, mu1);
   end

   task automatic press(input bit inc, input bit dec, input int low, input int high);
      @(negedge clk);
      if (inc) inc_key = 1'b0;
      if (dec) dec_key = 1'b0;
      repeat (low) @(negedge clk);
      inc_key = 1'b1;
      dec_key = 1'b1;
      repeat (high) @(negedge clk);
   endtask

   task automatic do_clear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("reset_digits", digits0, 0);
      chk("reset_en", en0, 6'b000001);
      chk("reset_en_noblank", en1, 2'b11);
      @(negedge clk);
      inc_key = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 chk("latency_e2", digits0, 0);
      @(posedge clk);
      #1 chk("latency_e3", digits0, 1);
      repeat (3) @(negedge clk);
      inc_key = 1'b1;
      repeat (4) @(negedge clk);
      chk("hold_one_event", digits0, 24'h000001);
      repeat (11) press(1, 0, 5, 4);
      chk("twelve", digits0, 24'h000012);
      chk("twelve_en", en0, 6'b000011);
      chk("twelve_sat", digits1, 8'h12);
      do_clear();
      press(0, 1, 2, 4);
      chk("wrap_down", digits0, 24'h999999);
      chk("wrap_down_en", en0, 6'b111111);
      chk("sat_down", digits1, 8'h00);
      press(1, 0, 2, 4);
      chk("wrap_up", digits0, 24'h000000);
      chk("wrap_up_en", en0, 6'b000001);
      repeat (100) press(1, 0, $urandom_range(1, 3), $urandom_range(1, 3));
      repeat (4) @(negedge clk);
      chk("hundred", digits0, 24'h000100);
      chk("sat_up", digits1, 8'h99);
      press(0, 1, 2, 4);
      chk("borrow", digits0, 24'h000099);
      chk("borrow_en", en0, 6'b000011);
      chk("sat_dec", digits1, 8'h98);
      press(1, 1, 3, 4);
      chk("both_keys", digits0, 24'h000099);
      do_clear();
      repeat (42) press(1, 0, $urandom_range(1, 3), $urandom_range(1, 3));
      repeat (4) @(negedge clk);
      chk("forty_two", digits0, 24'h000042);
      @(negedge clk);
      inc_key = 1'b0;
      @(negedge clk);
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      inc_key = 1'b1;
      repeat (4) @(negedge clk);
      chk("clear_wins", digits0, 24'h000000);
      repeat (600) begin
         @(negedge clk);
         inc_key = 1'($urandom_range(0, 1));
         dec_key = ($urandom_range(0, 2) != 0);
         clear = ($urandom_range(0, 59) == 0);
      end
      inc_key = 1'b1;
      dec_key = 1'b1;
      clear = 1'b0;
      repeat (4) @(negedge clk);
      do_clear();
      repeat (7) press(1, 0, 2, 3);
      repeat (3) @(negedge clk);
      chk("seven", digits0, 24'h000007);
      @(negedge clk);
      inc_key = 1'b0;
      @(posedge clk);
      #3 reset_n = 1'b0;
      #1 chk("async_rst_digits", digits0, 0);
      chk("async_rst_en", en0, 6'b000001);
      @(negedge clk);
      inc_key = 1'b1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("after_rst", digits0, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
